// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file controller.
package spi_regfile_pkg;

    typedef enum logic [2:0] {IDLE, HDR, WR_DATA, RD_DATA, DONE} state_e;

    localparam logic CMD_WRITE = 1'b1;

    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regfile_ctrl_if.sv
// Pin-side and register-side signals of the SPI register-file controller.
interface spi_regfile_ctrl_if #(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 8
);
    logic                         sclk;
    logic                         ncs;
    logic                         copi;
    logic                         cipo;
    logic                         cipo_oe;
    logic [NUM_REGS*DATA_W-1:0]   regs_out;
    logic                         wr_strobe;
    logic [ADDR_W-1:0]            wr_addr;
    logic                         frame_err;

    modport master (
        output sclk, ncs, copi,
        input  cipo, cipo_oe, regs_out, wr_strobe, wr_addr, frame_err
    );

    modport slave (
        input  sclk, ncs, copi,
        output cipo, cipo_oe, regs_out, wr_strobe, wr_addr, frame_err
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, plus one flop for edge detection.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/spi_regfile_ctrl.sv
// SPI mode-0 peripheral mapping write/read frames onto NUM_REGS registers with read-back,
// range checking, frame-length checking and commit strobes.
module spi_regfile_ctrl
    import spi_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_regfile_ctrl_if.slave bus
);
    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    logic w_sclk_rise, w_sclk_level_unused, w_sclk_fall_unused;
    logic w_ncs_rise, w_ncs_fall, w_ncs_level_unused;
    logic w_copi, w_copi_rise_unused, w_copi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .rst     (rst_n),
        .i_d     (bus.sclk),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall_unused)
    );

    // nCS idles high, so reset its chain high to avoid a spurious edge.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk     (clk),
        .rst     (rst_n),
        .i_d     (bus.ncs),
        .o_level (w_ncs_level_unused),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk     (clk),
        .rst     (rst_n),
        .i_d     (bus.copi),
        .o_level (w_copi),
        .o_rise  (w_copi_rise_unused),
        .o_fall  (w_copi_fall_unused)
    );

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-1:0] r_shift, w_shift_nxt;
    logic               r_overrun;
    logic [DATA_W-1:0]  r_shadow;
    logic [DATA_W-1:0]  r_regs [NUM_REGS];
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_wr_strobe, r_frame_err;

    logic               w_hdr_done, w_data_done, w_end;
    logic               w_frame_wr, w_addr_ok;
    logic [ADDR_W-1:0]  w_frame_addr;
    logic [DATA_W-1:0]  w_frame_data, w_rd_val;
    logic               w_commit, w_err, w_cipo_oe;

    assign w_shift_nxt  = {r_shift[FRAME_W-2:0], w_copi};
    assign w_hdr_done   = (r_state == HDR) && w_sclk_rise && (r_cnt == CNT_W'(ADDR_W));
    assign w_data_done  = ((r_state == WR_DATA) || (r_state == RD_DATA)) && w_sclk_rise
                          && (r_cnt == CNT_W'(FRAME_W - 1));
    assign w_frame_wr   = (r_shift[FRAME_W-1] == CMD_WRITE);
    assign w_frame_addr = r_shift[DATA_W +: ADDR_W];
    assign w_frame_data = r_shift[DATA_W-1:0];
    assign w_addr_ok    = 32'(w_frame_addr) < NUM_REGS;

    // Shadow source: the address just completed by this sclk rise; zero if out of range.
    always_comb begin
        w_rd_val = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (w_shift_nxt[ADDR_W-1:0] == ADDR_W'(r)) w_rd_val = r_regs[r];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state != IDLE && w_ncs_rise) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_ncs_fall) w_state_nxt = HDR;
                HDR:     if (w_hdr_done)
                             w_state_nxt = (w_shift_nxt[ADDR_W] == CMD_WRITE) ? WR_DATA : RD_DATA;
                WR_DATA: if (w_data_done) w_state_nxt = DONE;
                RD_DATA: if (w_data_done) w_state_nxt = DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_end     = w_ncs_rise && (r_state != IDLE);
        w_commit  = w_end && (r_state == DONE) && !r_overrun && w_frame_wr && w_addr_ok;
        w_err     = w_end && ((r_state != DONE) || r_overrun || !w_addr_ok);
        w_cipo_oe = (r_state == RD_DATA) || ((r_state == DONE) && !w_frame_wr);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_overrun   <= 1'b0;
            r_shadow    <= '0;
            r_wr_addr   <= '0;
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            for (int unsigned r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_end) begin
                if (w_commit) begin
                    for (int unsigned r = 0; r < NUM_REGS; r++) begin
                        if (w_frame_addr == ADDR_W'(r)) r_regs[r] <= w_frame_data;
                    end
                    r_wr_addr   <= w_frame_addr;
                    r_wr_strobe <= 1'b1;
                end
                r_frame_err <= w_err;
                r_shadow    <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_ncs_fall) begin
                            r_cnt     <= '0;
                            r_shift   <= '0;
                            r_overrun <= 1'b0;
                            r_shadow  <= '0;
                        end
                    end
                    HDR, WR_DATA, RD_DATA: begin
                        if (w_sclk_rise) begin
                            r_shift <= w_shift_nxt;
                            r_cnt   <= r_cnt + 1'b1;
                            if (w_hdr_done)              r_shadow <= w_rd_val;
                            else if (r_state == RD_DATA) r_shadow <= {r_shadow[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: begin
                        if (w_sclk_rise) r_overrun <= 1'b1;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign bus.regs_out[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign bus.cipo      = w_cipo_oe & r_shadow[DATA_W-1];
    assign bus.cipo_oe   = w_cipo_oe;
    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_spi_regfile_ctrl.sv
// Directed bench for spi_regfile_ctrl: writes, read-back, short/overrun/out-of-range frames, reset.
module tb_spi_regfile_ctrl;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    spi_regfile_ctrl_if #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8)) bus ();

    spi_regfile_ctrl #(.NUM_REGS(5), .ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int n_strobe = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (bus.wr_strobe) n_strobe <= n_strobe + 1;
        if (bus.frame_err) n_err <= n_err + 1;
    end

    logic [7:0] rd_byte;
    int         oe_hi, oe_lo;
    logic       oe_end;
    int         s0, e0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sends nbits of frame MSB-first; records cipo/cipo_oe as seen at each sclk rise.
    task automatic xfer(input logic [31:0] frame, input int nbits, input bit end_frame);
        int bitno;
        rd_byte = '0;
        oe_hi   = 0;
        oe_lo   = 0;
        oe_end  = 1'b0;
        bus.ncs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.copi = frame[i];
            repeat (HALF) @(negedge clk);
            bitno = nbits - i;
            if (bitno >= 9 && bitno <= 16) begin
                rd_byte = {rd_byte[6:0], bus.cipo};
                if (bus.cipo_oe) oe_hi++;
            end else if (bitno <= 8) begin
                if (bus.cipo_oe) oe_lo++;
            end
            bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (end_frame) begin
            oe_end  = bus.cipo_oe;
            bus.ncs = 1'b1;
            repeat (12) @(negedge clk);
        end
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.ncs  = 1'b1;
        bus.copi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);

        check("rst_regs", 64'(bus.regs_out), 64'h0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'h0);
        check("rst_cipo", 64'(bus.cipo), 64'h0);
        check("rst_cipo_oe", 64'(bus.cipo_oe), 64'h0);
        check("rst_pulses", 64'(n_strobe + n_err), 64'h0);

        // Write 0xA5 to reg2
        s0 = n_strobe; e0 = n_err;
        xfer(32'h82A5, 16, 1'b1);
        check("wr2_strobe", 64'(n_strobe - s0), 64'd1);
        check("wr2_err", 64'(n_err - e0), 64'd0);
        check("wr2_addr", 64'(bus.wr_addr), 64'd2);
        check("wr2_regs", 64'(bus.regs_out), 64'h00_0000_A5_0000);

        // Write 0x3C to reg4
        s0 = n_strobe; e0 = n_err;
        xfer(32'h843C, 16, 1'b1);
        check("wr4_strobe", 64'(n_strobe - s0), 64'd1);
        check("wr4_addr", 64'(bus.wr_addr), 64'd4);
        check("wr4_regs", 64'(bus.regs_out), 64'h3C_00A5_0000);

        // Read reg4
        s0 = n_strobe; e0 = n_err;
        xfer(32'h0400, 16, 1'b1);
        check("rd4_data", 64'(rd_byte), 64'h3C);
        check("rd4_oe_data", 64'(oe_hi), 64'd8);
        check("rd4_oe_hdr", 64'(oe_lo), 64'd0);
        check("rd4_oe_done", 64'(oe_end), 64'd1);
        check("rd4_oe_after", 64'(bus.cipo_oe), 64'd0);
        check("rd4_cipo_after", 64'(bus.cipo), 64'd0);
        check("rd4_strobe", 64'(n_strobe - s0), 64'd0);
        check("rd4_err", 64'(n_err - e0), 64'd0);
        check("rd4_regs", 64'(bus.regs_out), 64'h3C_00A5_0000);

        // Short write frame (10 bits of 0x80FF)
        s0 = n_strobe; e0 = n_err;
        xfer(32'h80FF >> 6, 10, 1'b1);
        check("short_err", 64'(n_err - e0), 64'd1);
        check("short_strobe", 64'(n_strobe - s0), 64'd0);
        check("short_regs", 64'(bus.regs_out), 64'h3C_00A5_0000);

        // Overrun write frame (0x82FF plus one extra bit)
        s0 = n_strobe; e0 = n_err;
        xfer(32'h82FF << 1, 17, 1'b1);
        check("ovr_err", 64'(n_err - e0), 64'd1);
        check("ovr_strobe", 64'(n_strobe - s0), 64'd0);
        check("ovr_regs", 64'(bus.regs_out), 64'h3C_00A5_0000);

        // Out-of-range write and read
        s0 = n_strobe; e0 = n_err;
        xfer(32'h85FF, 16, 1'b1);
        check("oor_wr_err", 64'(n_err - e0), 64'd1);
        check("oor_wr_strobe", 64'(n_strobe - s0), 64'd0);
        check("oor_wr_regs", 64'(bus.regs_out), 64'h3C_00A5_0000);
        check("oor_wr_addr", 64'(bus.wr_addr), 64'd4);
        s0 = n_strobe; e0 = n_err;
        xfer(32'h0500, 16, 1'b1);
        check("oor_rd_data", 64'(rd_byte), 64'h00);
        check("oor_rd_err", 64'(n_err - e0), 64'd1);
        check("oor_rd_strobe", 64'(n_strobe - s0), 64'd0);

        // Reset after bit 12 of a write to reg0
        s0 = n_strobe; e0 = n_err;
        xfer(32'h80A, 12, 1'b0);
        rst_n = 1'b1;
        bus.ncs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_rst_regs", 64'(bus.regs_out), 64'h0);
        check("mid_rst_addr", 64'(bus.wr_addr), 64'h0);
        check("mid_rst_oe", 64'(bus.cipo_oe), 64'h0);
        check("mid_rst_pulses", 64'((n_strobe - s0) + (n_err - e0)), 64'd0);

        s0 = n_strobe; e0 = n_err;
        xfer(32'h8011, 16, 1'b1);
        check("post_rst_regs", 64'(bus.regs_out), 64'h11);
        check("post_rst_strobe", 64'(n_strobe - s0), 64'd1);
        check("post_rst_err", 64'(n_err - e0), 64'd0);
        check("post_rst_addr", 64'(bus.wr_addr), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
